pipeline_hazard_ctrl: RTL and testbench

Sequencing controller for the 5-stage pipeline. It drives the enable and flush controls of the PC register and of the IF/ID, ID/EX and EX/MEM segment registers. It keeps a shadow scoreboard of in-flight destination registers and detects read-after-write and load-use hazards. It also handles taken-branch flushes, multi-cycle execute stalls and a terminal halt.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 39 +++
 rtl/pipeline_hazard_ctrl_if.sv | 48 ++++
 rtl/pipeline_hazard_ctrl_hazard_compare.sv | 36 +++
 rtl/pipeline_hazard_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_ctrl_pkg
// Brief   : Shared types and constants for the pipeline hazard controller.
// Revision: 1.0
// ============================================================================
package pipeline_ctrl_pkg;

    // Shadow slots store register indices at this fixed width; NREG_W must not exceed it.
    localparam int MAX_NREG_W = 8;

    localparam logic [MAX_NREG_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        ACT_RUN    = 3'd0,
        ACT_STALL  = 3'd1,
        ACT_FREEZE = 3'd2,
        ACT_FLUSH  = 3'd3,
        ACT_HALTED = 3'd4
    } action_t;

    typedef struct packed {
        logic                  valid;
        logic [MAX_NREG_W-1:0] rd;
        logic                  we;
        logic                  is_load;
    } shadow_t;

    localparam shadow_t SHADOW_EMPTY = '{valid: 1'b0, rd: REG_ZERO, we: 1'b0, is_load: 1'b0};

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_hazard_ctrl_if
// Brief   : Decode/execute status in, segment-register controls and counters out.
// Revision: 1.0
// ============================================================================
interface pipeline_hazard_ctrl_if #(
    parameter int NREG_W = 4,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [NREG_W-1:0] id_rs1;
    logic [NREG_W-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [NREG_W-1:0] id_rd;
    logic              id_we;
    logic              id_is_load;
    logic              id_halt;
    logic              ex_branch_taken;
    logic              ex_busy;

    logic              pc_en;
    logic              pc_sel_branch;
    logic              if_id_en;
    logic              if_id_flush;
    logic              id_ex_en;
    logic              id_ex_bubble;
    logic              ex_mem_en;
    logic              halted;
    logic [CNT_W-1:0]  stall_cycles;
    logic [CNT_W-1:0]  flush_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_we, id_is_load, id_halt, ex_branch_taken, ex_busy,
        input  pc_en, pc_sel_branch, if_id_en, if_id_flush, id_ex_en,
               id_ex_bubble, ex_mem_en, halted, stall_cycles, flush_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_we, id_is_load, id_halt, ex_branch_taken, ex_busy,
        output pc_en, pc_sel_branch, if_id_en, if_id_flush, id_ex_en,
               id_ex_bubble, ex_mem_en, halted, stall_cycles, flush_count
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_hazard_compare.sv
`default_nettype none
// ============================================================================
// Module  : hazard_compare
// Brief   : Matches the two decoded source operands against one shadow slot.
// Revision: 1.0
// ============================================================================
module hazard_compare
    import pipeline_ctrl_pkg::*;
#(
    parameter int NREG_W = 4
) (
    input  logic [NREG_W-1:0] i_rs1,
    input  logic [NREG_W-1:0] i_rs2,
    input  logic              i_rs1_used,
    input  logic              i_rs2_used,
    input  shadow_t           i_slot,
    input  logic              i_need_load,
    output logic              o_hit
);
    logic [MAX_NREG_W-1:0] w_rs1_ext;
    logic [MAX_NREG_W-1:0] w_rs2_ext;
    logic                  w_writer;
    logic                  w_src_match;

    assign w_rs1_ext = MAX_NREG_W'(i_rs1);
    assign w_rs2_ext = MAX_NREG_W'(i_rs2);

    // r0 is hard-wired zero, so a write to it never creates a dependency.
    assign w_writer    = i_slot.valid && i_slot.we && (i_slot.rd != REG_ZERO)
                         && (!i_need_load || i_slot.is_load);
    assign w_src_match = (i_rs1_used && (w_rs1_ext == i_slot.rd))
                         || (i_rs2_used && (w_rs2_ext == i_slot.rd));
    assign o_hit       = w_writer && w_src_match;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_hazard_ctrl
// Brief   : 5-stage pipeline sequencing: hazard stalls, branch flush, EX freeze, halt.
// Revision: 1.0
// ============================================================================
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int FORWARD = 1,
    parameter int NREG_W  = 4,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam logic c_need_load = (FORWARD != 0);

    state_t           r_state;
    state_t           w_state_nxt;
    action_t          w_act;
    shadow_t          r_ex;
    shadow_t          r_mem;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_hit_ex;
    logic w_hit_mem;
    logic w_hit_mem_used;
    logic w_hazard;

    logic w_pc_en;
    logic w_pc_sel;
    logic w_if_id_en;
    logic w_if_id_flush;
    logic w_id_ex_en;
    logic w_id_ex_bubble;
    logic w_ex_mem_en;
    logic w_halted;
    logic w_count_stall;
    logic w_count_flush;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    hazard_compare #(.NREG_W(NREG_W)) u_cmp_ex (
        .i_rs1       (bus.id_rs1),
        .i_rs2       (bus.id_rs2),
        .i_rs1_used  (bus.id_rs1_used),
        .i_rs2_used  (bus.id_rs2_used),
        .i_slot      (r_ex),
        .i_need_load (c_need_load),
        .o_hit       (w_hit_ex)
    );

    hazard_compare #(.NREG_W(NREG_W)) u_cmp_mem (
        .i_rs1       (bus.id_rs1),
        .i_rs2       (bus.id_rs2),
        .i_rs1_used  (bus.id_rs1_used),
        .i_rs2_used  (bus.id_rs2_used),
        .i_slot      (r_mem),
        .i_need_load (1'b0),
        .o_hit       (w_hit_mem)
    );

    // With forwarding a writer in MEM is always bypassed.
    generate
        if (FORWARD != 0) begin : g_fwd
            assign w_hit_mem_used = 1'b0;
        end else begin : g_nofwd
            assign w_hit_mem_used = w_hit_mem;
        end
    endgenerate

    assign w_hazard = bus.id_valid && (w_hit_ex || w_hit_mem_used);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FLUSH lasts one cycle and decides like RUN; only HALT changes the decision.
    always_comb begin
        w_act       = ACT_RUN;
        w_state_nxt = ST_RUN;
        if (r_state == ST_HALT) begin
            w_act       = ACT_HALTED;
            w_state_nxt = ST_HALT;
        end else if (bus.ex_branch_taken) begin
            w_act       = ACT_FLUSH;
            w_state_nxt = ST_FLUSH;
        end else if (bus.ex_busy) begin
            w_act       = ACT_FREEZE;
            w_state_nxt = r_state;
        end else if (w_hazard) begin
            w_act       = ACT_STALL;
            w_state_nxt = ST_STALL;
        end else if (bus.id_valid && bus.id_halt) begin
            w_act       = ACT_RUN;
            w_state_nxt = ST_HALT;
        end
    end

    // Reset forces the RUN control pattern regardless of the live inputs.
    always_comb begin
        w_pc_en        = 1'b1;
        w_pc_sel       = 1'b0;
        w_if_id_en     = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_en     = 1'b1;
        w_id_ex_bubble = 1'b0;
        w_ex_mem_en    = 1'b1;
        w_halted       = 1'b0;
        w_count_stall  = 1'b0;
        w_count_flush  = 1'b0;
        if (!rst) begin
            unique case (w_act)
                ACT_STALL: begin
                    w_pc_en        = 1'b0;
                    w_if_id_en     = 1'b0;
                    w_id_ex_bubble = 1'b1;
                    w_count_stall  = 1'b1;
                end
                ACT_FREEZE: begin
                    w_pc_en       = 1'b0;
                    w_if_id_en    = 1'b0;
                    w_id_ex_en    = 1'b0;
                    w_ex_mem_en   = 1'b0;
                    w_count_stall = 1'b1;
                end
                ACT_FLUSH: begin
                    w_pc_sel       = 1'b1;
                    w_if_id_flush  = 1'b1;
                    w_id_ex_bubble = 1'b1;
                    w_count_flush  = 1'b1;
                end
                ACT_HALTED: begin
                    w_pc_en        = 1'b0;
                    w_if_id_en     = 1'b0;
                    w_id_ex_bubble = 1'b1;
                    w_halted       = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex  <= SHADOW_EMPTY;
            r_mem <= SHADOW_EMPTY;
        end else begin
            if (w_id_ex_en) begin
                if (w_id_ex_bubble) begin
                    r_ex.valid <= 1'b0;
                end else begin
                    r_ex <= '{valid:   bus.id_valid,
                              rd:      MAX_NREG_W'(bus.id_rd),
                              we:      bus.id_we,
                              is_load: bus.id_is_load};
                end
            end
            // While EX is frozen the MEM occupant retires, leaving MEM empty.
            if (w_ex_mem_en) begin
                r_mem <= r_ex;
            end else if (w_act == ACT_FREEZE) begin
                r_mem.valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_count_stall) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
            if (w_count_flush) begin
                r_flush_cnt <= sat_inc(r_flush_cnt);
            end
        end
    end

    assign bus.pc_en         = w_pc_en;
    assign bus.pc_sel_branch = w_pc_sel;
    assign bus.if_id_en      = w_if_id_en;
    assign bus.if_id_flush   = w_if_id_flush;
    assign bus.id_ex_en      = w_id_ex_en;
    assign bus.id_ex_bubble  = w_id_ex_bubble;
    assign bus.ex_mem_en     = w_ex_mem_en;
    assign bus.halted        = w_halted;
    assign bus.stall_cycles  = r_stall_cnt;
    assign bus.flush_count   = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipeline_hazard_ctrl
// Brief   : Directed and random checks of both FORWARD variants against a pipeline model.
// Revision: 1.0
// ============================================================================
module tb_pipeline_hazard_ctrl;
    localparam int NW = 4;
    localparam int CW = 5;
    localparam logic [CW-1:0] CMAX = '1;

    typedef struct packed {
        logic          v;
        logic [NW-1:0] rs1;
        logic [NW-1:0] rs2;
        logic          u1;
        logic          u2;
        logic [NW-1:0] rd;
        logic          we;
        logic          ld;
        logic          hl;
    } ins_t;

    typedef struct packed {
        logic          v;
        logic [NW-1:0] rd;
        logic          we;
        logic          ld;
    } rec_t;

    localparam ins_t NOP = '0;
    localparam int A_RUN = 0, A_STALL = 1, A_FREEZE = 2, A_FLUSH = 3, A_HALTED = 4;
    // control vector order: pc_en, pc_sel_branch, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, halted
    localparam logic [7:0] V_RUN = 8'b1010_1010;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic br  = 1'b0;
    logic busy = 1'b0;
    ins_t in_q [2];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.NREG_W(NW), .CNT_W(CW)) bus0 ();
    pipeline_hazard_ctrl_if #(.NREG_W(NW), .CNT_W(CW)) bus1 ();

    assign bus0.id_valid = in_q[0].v;   assign bus1.id_valid = in_q[1].v;
    assign bus0.id_rs1 = in_q[0].rs1;   assign bus1.id_rs1 = in_q[1].rs1;
    assign bus0.id_rs2 = in_q[0].rs2;   assign bus1.id_rs2 = in_q[1].rs2;
    assign bus0.id_rs1_used = in_q[0].u1; assign bus1.id_rs1_used = in_q[1].u1;
    assign bus0.id_rs2_used = in_q[0].u2; assign bus1.id_rs2_used = in_q[1].u2;
    assign bus0.id_rd = in_q[0].rd;     assign bus1.id_rd = in_q[1].rd;
    assign bus0.id_we = in_q[0].we;     assign bus1.id_we = in_q[1].we;
    assign bus0.id_is_load = in_q[0].ld; assign bus1.id_is_load = in_q[1].ld;
    assign bus0.id_halt = in_q[0].hl;   assign bus1.id_halt = in_q[1].hl;
    assign bus0.ex_branch_taken = br;   assign bus1.ex_branch_taken = br;
    assign bus0.ex_busy = busy;         assign bus1.ex_busy = busy;

    pipeline_hazard_ctrl #(.FORWARD(0), .NREG_W(NW), .CNT_W(CW)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    pipeline_hazard_ctrl #(.FORWARD(1), .NREG_W(NW), .CNT_W(CW)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    logic [7:0]    obs_ctl [2];
    logic [CW-1:0] obs_sc  [2];
    logic [CW-1:0] obs_fc  [2];
    assign obs_ctl[0] = {bus0.pc_en, bus0.pc_sel_branch, bus0.if_id_en, bus0.if_id_flush,
                         bus0.id_ex_en, bus0.id_ex_bubble, bus0.ex_mem_en, bus0.halted};
    assign obs_ctl[1] = {bus1.pc_en, bus1.pc_sel_branch, bus1.if_id_en, bus1.if_id_flush,
                         bus1.id_ex_en, bus1.id_ex_bubble, bus1.ex_mem_en, bus1.halted};
    assign obs_sc[0] = bus0.stall_cycles;  assign obs_sc[1] = bus1.stall_cycles;
    assign obs_fc[0] = bus0.flush_count;   assign obs_fc[1] = bus1.flush_count;

    // Model: the instructions sitting in EX and MEM, a halted flag and the two counters.
    rec_t          m_ex   [2];
    rec_t          m_mem  [2];
    logic          m_halt [2];
    logic [CW-1:0] m_sc   [2];
    logic [CW-1:0] m_fc   [2];
    int            m_act  [2];
    logic          acc    [2];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    function automatic logic reads(rec_t r, ins_t i, logic need_ld);
        if (!r.v || !r.we || r.rd == '0) return 1'b0;
        if (need_ld && !r.ld) return 1'b0;
        return (i.u1 && i.rs1 == r.rd) || (i.u2 && i.rs2 == r.rd);
    endfunction

    function automatic int decide(int d);
        if (m_halt[d]) return A_HALTED;
        if (br) return A_FLUSH;
        if (busy) return A_FREEZE;
        if (in_q[d].v && (d == 1 ? reads(m_ex[d], in_q[d], 1'b1)
                                 : (reads(m_ex[d], in_q[d], 1'b0) || reads(m_mem[d], in_q[d], 1'b0))))
            return A_STALL;
        return A_RUN;
    endfunction

    function automatic logic [7:0] outs(int a);
        case (a)
            A_STALL:  return 8'b0000_1110;
            A_FREEZE: return 8'b0000_0000;
            A_FLUSH:  return 8'b1111_1110;
            A_HALTED: return 8'b0000_1111;
            default:  return V_RUN;
        endcase
    endfunction

    function automatic logic [CW-1:0] sat(logic [CW-1:0] v);
        return (v == CMAX) ? v : v + 1'b1;
    endfunction

    function automatic ins_t mk(int rs1, int u1, int rs2, int u2, int rd, int we, int ld, int hl);
        ins_t r;
        r.v = 1'b1; r.rs1 = NW'(rs1); r.u1 = 1'(u1); r.rs2 = NW'(rs2); r.u2 = 1'(u2);
        r.rd = NW'(rd); r.we = 1'(we); r.ld = 1'(ld); r.hl = 1'(hl);
        return r;
    endfunction

    function automatic ins_t rnd_ins();
        ins_t r;
        r.v   = ($urandom_range(0, 5) != 0);
        r.rs1 = NW'($urandom_range(0, 3));
        r.rs2 = NW'($urandom_range(0, 3));
        r.u1  = 1'($urandom_range(0, 1));
        r.u2  = 1'($urandom_range(0, 1));
        r.rd  = NW'($urandom_range(0, 3));
        r.we  = 1'($urandom_range(0, 1));
        r.ld  = 1'($urandom_range(0, 1));
        r.hl  = ($urandom_range(0, 149) == 0);
        return r;
    endfunction

    // Called just after a rising edge: check mid-cycle, then advance the model at the edge.
    task automatic step(input string tag);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            m_act[d] = decide(d);
            chk({tag, "_ctl"}, d, 32'(obs_ctl[d]), 32'(outs(m_act[d])));
            chk({tag, "_stall_cycles"}, d, 32'(obs_sc[d]), 32'(m_sc[d]));
            chk({tag, "_flush_count"}, d, 32'(obs_fc[d]), 32'(m_fc[d]));
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            case (m_act[d])
                A_FLUSH:  begin m_mem[d] = m_ex[d]; m_ex[d].v = 1'b0; m_fc[d] = sat(m_fc[d]); end
                A_FREEZE: begin m_mem[d].v = 1'b0; m_sc[d] = sat(m_sc[d]); end
                A_STALL:  begin m_mem[d] = m_ex[d]; m_ex[d].v = 1'b0; m_sc[d] = sat(m_sc[d]); end
                A_HALTED: begin m_mem[d] = m_ex[d]; m_ex[d].v = 1'b0; end
                default: begin
                    m_mem[d] = m_ex[d];
                    m_ex[d]  = '{v: in_q[d].v, rd: in_q[d].rd, we: in_q[d].we, ld: in_q[d].ld};
                    if (in_q[d].v && in_q[d].hl) m_halt[d] = 1'b1;
                end
            endcase
            acc[d] = (m_act[d] == A_RUN) || (m_act[d] == A_FLUSH) || (m_act[d] == A_HALTED);
        end
        #1;
    endtask

    // Asserted between clock edges so the checks see the asynchronous effect.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_ctl", d, 32'(obs_ctl[d]), 32'(V_RUN));
            chk("rst_stall_cycles", d, 32'(obs_sc[d]), 32'd0);
            chk("rst_flush_count", d, 32'(obs_fc[d]), 32'd0);
            m_ex[d] = '0; m_mem[d] = '0; m_halt[d] = 1'b0;
            m_sc[d] = '0; m_fc[d] = '0; acc[d] = 1'b1;
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Presents one instruction to both pipes, holding it while each one stalls.
    task automatic issue(input ins_t i, input string tag, output int st0, output int st1);
        logic done [2];
        int   st   [2];
        for (int d = 0; d < 2; d++) begin in_q[d] = i; done[d] = 1'b0; st[d] = 0; end
        for (int k = 0; k < 12 && !(done[0] && done[1]); k++) begin
            step(tag);
            for (int d = 0; d < 2; d++) begin
                if (!done[d]) begin
                    if (m_act[d] == A_STALL || m_act[d] == A_FREEZE) st[d]++;
                    else begin done[d] = 1'b1; in_q[d] = NOP; end
                end
            end
        end
        for (int d = 0; d < 2; d++) chk({tag, "_issue_done"}, d, 32'(done[d]), 32'd1);
        st0 = st[0];
        st1 = st[1];
    endtask

    int s0, s1, hcnt;

    initial begin
        in_q[0] = NOP; in_q[1] = NOP;
        @(posedge clk);
        #1;
        do_reset();

        // Load-use: one stall with forwarding, two without.
        issue(mk(0, 0, 0, 0, 3, 1, 1, 0), "lu_load", s0, s1);
        issue(mk(3, 1, 5, 1, 4, 1, 0, 0), "lu_use", s0, s1);
        chk("lu_stalls", 1, 32'(s1), 32'd1);
        chk("lu_stalls", 0, 32'(s0), 32'd2);
        chk("lu_stall_cycles", 1, 32'(obs_sc[1]), 32'd1);

        // RAW back-to-back, then with one independent instruction between.
        do_reset();
        issue(mk(0, 0, 0, 0, 2, 1, 0, 0), "raw_add", s0, s1);
        issue(mk(2, 1, 1, 1, 6, 1, 0, 0), "raw_sub", s0, s1);
        chk("raw_ex_stalls", 0, 32'(s0), 32'd2);
        chk("raw_ex_stalls", 1, 32'(s1), 32'd0);
        do_reset();
        issue(mk(0, 0, 0, 0, 2, 1, 0, 0), "raw2_add", s0, s1);
        issue(mk(8, 1, 9, 1, 7, 1, 0, 0), "raw2_ind", s0, s1);
        issue(mk(2, 1, 1, 1, 6, 1, 0, 0), "raw2_sub", s0, s1);
        chk("raw_mem_stalls", 0, 32'(s0), 32'd1);

        // r0 destinations/sources and unused rs2 never stall.
        do_reset();
        issue(mk(0, 0, 0, 0, 0, 1, 1, 0), "r0_load", s0, s1);
        issue(mk(0, 1, 0, 1, 5, 1, 0, 0), "r0_use", s0, s1);
        chk("r0_stalls", 0, 32'(s0 + s1), 32'd0);
        issue(mk(0, 0, 0, 0, 5, 1, 1, 0), "u2_load", s0, s1);
        issue(mk(1, 1, 5, 0, 6, 1, 0, 0), "u2_use", s0, s1);
        chk("rs2_unused_stalls", 0, 32'(s0 + s1), 32'd0);

        // Branch during a pending load-use: flush wins.
        do_reset();
        issue(mk(0, 0, 0, 0, 3, 1, 1, 0), "br_load", s0, s1);
        in_q[0] = mk(3, 1, 5, 1, 4, 1, 0, 0); in_q[1] = in_q[0];
        br = 1'b1;
        step("br_flush");
        br = 1'b0; in_q[0] = NOP; in_q[1] = NOP;
        chk("br_flush_count", 1, 32'(obs_fc[1]), 32'd1);
        chk("br_stall_cycles", 1, 32'(obs_sc[1]), 32'd0);
        step("br_after");

        // Four-cycle EX freeze; the pending load in EX must still stall afterwards.
        do_reset();
        issue(mk(0, 0, 0, 0, 3, 1, 1, 0), "busy_load", s0, s1);
        in_q[0] = mk(3, 1, 5, 1, 4, 1, 0, 0); in_q[1] = in_q[0];
        busy = 1'b1;
        repeat (4) step("busy");
        busy = 1'b0;
        chk("busy_stall_cycles", 1, 32'(obs_sc[1]), 32'd4);
        issue(mk(3, 1, 5, 1, 4, 1, 0, 0), "busy_use", s0, s1);
        chk("busy_then_lu_stalls", 1, 32'(s1), 32'd1);

        // Counter saturation.
        do_reset();
        busy = 1'b1;
        repeat (40) step("sat");
        busy = 1'b0;
        chk("sat_stall_cycles", 1, 32'(obs_sc[1]), 32'(CMAX));

        // HALT ignores branches and holds until reset.
        do_reset();
        issue(mk(0, 0, 0, 0, 0, 0, 0, 1), "halt_issue", s0, s1);
        in_q[0] = mk(1, 1, 2, 1, 3, 1, 0, 0); in_q[1] = in_q[0];
        br = 1'b1;
        repeat (3) step("halted");
        br = 1'b0;
        chk("halted_bit", 1, 32'(bus1.halted), 32'd1);
        do_reset();

        // Random traffic, each pipe fetching a new instruction only when ID was consumed.
        hcnt = 0;
        for (int c = 0; c < 800; c++) begin
            for (int d = 0; d < 2; d++) if (acc[d]) in_q[d] = rnd_ins();
            br   = ($urandom_range(0, 9) == 0);
            busy = ($urandom_range(0, 5) == 0);
            step("rand");
            if (m_halt[0] && m_halt[1]) begin
                hcnt++;
                if (hcnt > 3) begin
                    br = 1'b0; busy = 1'b0;
                    do_reset();
                    hcnt = 0;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
